lamp_sched: RTL and testbench
=============================

# lamp_sched

Three-switch lamp scheduler that shares a single lamp output among switches S1–S3. Each switch press claims ownership and (re)arms an on-timer. The lamp turns off on timeout, or immediately when the current owner presses again. It sits between the raw switch inputs and the lamp drive F, replacing ad-hoc switch-to-lamp logic with one arbitrated, timed controller.

## Interface
- CNT_W, 8, on-timer width; the lamp stays lit for 2^CNT_W cycles after an arm.
- WARN_CYC, 16, length of the pre-off warning window in cycles.
  - Must be a multiple of 8.
  - Must be ≤ 2^(CNT_W-1).
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- S1  input  1  switch 1, level; a press is a 0→1 transition.
- S2  input  1  switch 2, as S1.
- S3  input  1  switch 3, as S1.
- F  output  1  lamp drive, registered.
- owner  output  2  current owner: 0 = none, 1/2/3 = S1/S2/S3.
- busy  output  1  1 while state is ON or WARN.

## Operation
- Input stage, per switch:
  - s_q is S registered; s_qq is s_q registered.
  - press = s_q & ~s_qq, a single-cycle pulse.
- Simultaneous presses: fixed priority S1 > S2 > S3. Only the winner is acted on that cycle; the others are dropped.
- cnt is a CNT_W-bit down-counter. "Arm" means: cnt ← 2^CNT_W−1, owner ← winner, state ← ON.
- States: IDLE, ON, WARN.
- IDLE:
  - press → arm.
  - No press → hold; F=0, owner=0, cnt=0.
- ON:
  - Press by the owner → IDLE: F=0, owner=0, cnt=0.
  - Press by a non-owner → arm (owner changes, timer restarts).
  - No press and cnt==WARN_CYC → WARN, cnt−1.
  - Otherwise → cnt−1.
- WARN:
  - Any press, owner or not → arm; the owner re-arms (extends) here and does not turn the lamp off.
  - No press and cnt==0 → IDLE, owner=0.
  - Otherwise → cnt−1.
- F:
  - ON → 1.
  - WARN → cnt[2] (blink, 4 cycles high / 4 cycles low, starting high).
  - IDLE → 0.
  - F is registered from the next-state and next-cnt values, so it changes on the same edge as the state.
- busy = (state != IDLE), registered.

## Timing
- Reset values (asynchronous assert, takes effect immediately): F=0, owner=0, busy=0, state=IDLE, cnt=0, s_q=0, s_qq=0.
- Press latency:
  - S first sampled high at edge n → press high during cycle n..n+1.
  - F, owner and busy update at edge n+1.
  - End to end: 2 rising edges from S sampled high to F rising.
- Lit duration with no further presses: exactly 2^CNT_W cycles, i.e. cnt values 2^CNT_W−1 down to 0 inclusive.
  - The last WARN_CYC of those cycles are WARN.
  - F falls at the edge after the cycle with cnt==0.
- Owner press in ON: F falls at edge n+1, with the same latency as turn-on.
- Press in the cnt==0 WARN cycle: the press wins; re-arm, F stays/becomes 1, no IDLE cycle.
- Held switch:
  - Generates exactly one press; it must go low for at least one sampled cycle before another press registers.
  - A switch held high across reset deassertion counts as a press 2 edges after rst_n rises.
- Reset mid-operation: immediate return to reset values; there is no pending state after release.

## Configuration
- LAMP_WARN_EN defined:
  - WARN state and blink behave as above.
  - Owner press in WARN re-arms.
- LAMP_WARN_EN undefined:
  - WARN is not implemented; ON covers the full count and F=1 throughout.
  - When cnt==0 and there is no press → IDLE.
  - Owner press anywhere while lit → IDLE.
  - WARN_CYC is ignored.
  - Lit duration and latency are unchanged.

## Test plan
All scenarios use CNT_W=8, WARN_CYC=16, 20 ns clock.
- S1 pulsed for 1 cycle at 100 ns, no other input → F=1 and owner=1 from 2 edges later.
  - Steady 1 for 240 cycles, then blink 1111 0000 1111 0000.
  - F=0 and owner=0 after 256 cycles total.
- S1 press, then S1 again 50 cycles later → F=0, owner=0, busy=0 two edges after the second press.
- S1 press, then S2 press 100 cycles later → owner=2 and cnt reloads to 255.
  - F stays 1 continuously; total lit time is 100 + 256 cycles.
- S1, S2 and S3 rise on the same cycle → owner=1.
  - S2 and S3 presses are dropped; a following S1 press turns the lamp off.
- Owner S1 presses during WARN (cnt=10) → re-arm: F=1 steady, owner=1, cnt=255.
  - Repeat with LAMP_WARN_EN undefined and the press at cnt=10 → F=0 two edges later.
- rst_n driven low for 1 ns at cnt=128 → F, owner and busy read 0 immediately.
  - S1 held high across rst_n release → F=1 two edges after release.

Source files
------------

// File: rtl/lamp_sched.sv
// -----------------------------------------------------------------------------
// lamp_sched -- three-switch lamp scheduler.
//
// Three switches share one lamp. A rising edge on a switch is a press. A press
// claims ownership of the lamp and (re)arms a 2^CNT_W-cycle on-timer. The lamp
// turns off when the timer runs out. It also turns off at once when the
// current owner presses again. When several switches are pressed in the same
// cycle, the fixed priority is S1 > S2 > S3.
//
// Optional feature: define LAMP_WARN_EN to enable the pre-off warning window.
// During the last WARN_CYC cycles the lamp blinks (4 cycles on, 4 cycles off).
// An owner press in that window re-arms the timer instead of turning the lamp
// off. With LAMP_WARN_EN undefined, the lamp is steady for the whole count.
//
// Parameters:
//   CNT_W     on-timer width; the lamp is lit for 2^CNT_W cycles per arm
//   WARN_CYC  warning window length (multiple of 8, <= 2^(CNT_W-1))
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   S1..S3     switch levels; a press is a sampled 0->1 transition
//   F          lamp drive (registered)
//   owner      0 = none, 1/2/3 = S1/S2/S3 (registered)
//   busy       1 while the lamp is lit (ON or WARN), registered
// -----------------------------------------------------------------------------
module lamp_sched #(
    parameter int CNT_W    = 8,
    parameter int WARN_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       S1,
    input  logic       S2,
    input  logic       S3,
    output logic       F,
    output logic [1:0] owner,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
`ifdef LAMP_WARN_EN
    localparam logic [1:0] ST_WARN = 2'd2;
    localparam logic [CNT_W-1:0] WARN_AT = CNT_W'(WARN_CYC);
`endif

    // A bad WARN_CYC would break the blink phase or leave no ON period.
    if (((WARN_CYC % 8) != 0) || (WARN_CYC > (1 << (CNT_W - 1)))) begin : g_bad_warn_cyc
        $error("lamp_sched: WARN_CYC must be a multiple of 8 and <= 2^(CNT_W-1)");
    end

    // ---------------- input stage: two flops and edge detect per switch ------
    logic [2:0] s_in;
    logic [2:0] s_q;
    logic [2:0] s_qq;
    logic [2:0] press;

    assign s_in = {S3, S2, S1};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q[gi]  <= 1'b0;
                s_qq[gi] <= 1'b0;
            end else begin
                s_q[gi]  <= s_in[gi];
                s_qq[gi] <= s_q[gi];
            end
        end
        assign press[gi] = s_q[gi] & ~s_qq[gi];
    end

    // Fixed priority S1 > S2 > S3. Presses that lose are dropped.
    logic       any_press;
    logic [1:0] win;

    assign any_press = |press;

    always_comb begin
        win = 2'd0;
        if (press[0])      win = 2'd1;
        else if (press[1]) win = 2'd2;
        else if (press[2]) win = 2'd3;
    end

    // ---------------- control state -----------------------------------------
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       owner_q, owner_d;
    logic             f_q, f_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (any_press) begin
                    state_d = ST_ON;
                    cnt_d   = '1;
                    owner_d = win;
                end else begin
                    cnt_d   = '0;
                    owner_d = 2'd0;
                end
            end
            ST_ON: begin
                if (any_press && (win == owner_q)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    owner_d = 2'd0;
                end else if (any_press) begin
                    state_d = ST_ON;
                    cnt_d   = '1;
                    owner_d = win;
`ifdef LAMP_WARN_EN
                end else if (cnt_q == WARN_AT) begin
                    state_d = ST_WARN;
                    cnt_d   = cnt_q - 1'b1;
`else
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    owner_d = 2'd0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef LAMP_WARN_EN
            ST_WARN: begin
                // Any press re-arms here, including one from the owner.
                if (any_press) begin
                    state_d = ST_ON;
                    cnt_d   = '1;
                    owner_d = win;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    owner_d = 2'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                owner_d = 2'd0;
            end
        endcase
    end

    // F and busy are computed from the next-state values, so they switch on
    // the same edge as the state. Bit 2 of the count gives a 4-on/4-off blink.
    // Because WARN_CYC is a multiple of 8, the blink starts with the high phase.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        f_d    = (state_d == ST_ON);
`ifdef LAMP_WARN_EN
        if (state_d == ST_WARN) f_d = cnt_d[2];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= 2'd0;
            f_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            f_q     <= f_d;
            busy_q  <= busy_d;
        end
    end

    assign F     = f_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_lamp_sched.sv
// -----------------------------------------------------------------------------
// tb_lamp_sched -- directed testbench for lamp_sched (CNT_W=8, WARN_CYC=16).
// The expectations follow whether LAMP_WARN_EN is defined, so the bench works
// in both builds. Outputs are sampled 1 ns after the rising edge, and inputs
// change at the same point.
// -----------------------------------------------------------------------------
module tb_lamp_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       S1 = 1'b0;
    logic       S2 = 1'b0;
    logic       S3 = 1'b0;
    logic       F;
    logic [1:0] owner;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    lamp_sched #(.CNT_W(8), .WARN_CYC(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .S1    (S1),
        .S2    (S2),
        .S3    (S3),
        .F     (F),
        .owner (owner),
        .busy  (busy)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ef, input logic [1:0] eo, input logic eb);
        chk(tag, {252'd0, F, owner, busy}, {252'd0, ef, eo, eb});
        $display("step %-16s F=%b owner=%0d busy=%b", tag, F, owner, busy);
    endtask

    // One-cycle pulse on the selected switches. On return, the arbitrated
    // press has taken effect (two edges after S is first sampled high).
    task automatic do_press(input logic [2:0] m);
        {S3, S2, S1} = m;
        tick();
        {S3, S2, S1} = 3'b000;
        tick();
    endtask

    // Counts the busy cycles starting from the current one, with a bound.
    task automatic count_lit(output int n);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            tick();
        end
    endtask

    logic [255:0] fvec;
    logic [255:0] fexp;
    int           lit;
    bit           warn_en;

    initial begin
`ifdef LAMP_WARN_EN
        warn_en = 1'b1;
`else
        warn_en = 1'b0;
`endif
        // Reset
        #5 rst_n = 1'b0;
        #1 chk_out("reset", 1'b0, 2'd0, 1'b0);
        #40 rst_n = 1'b1;
        ticks(3);
        chk_out("idle_after_rst", 1'b0, 2'd0, 1'b0);

        // Single S1 pulse: full lit period, then the blink, then off
        S1 = 1'b1;
        tick();
        S1 = 1'b0;
        chk_out("latency_1edge", 1'b0, 2'd0, 1'b0);
        tick();
        chk_out("s1_on", 1'b1, 2'd1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            fvec[i] = F;
            fexp[i] = (!warn_en || i < 240) ? 1'b1 : (((i - 240) / 4) % 2 == 0);
            tick();
        end
        chk("f_steady_240", {16'd0, fvec[239:0]}, {16'd0, fexp[239:0]});
        chk("f_warn_pattern", {240'd0, fvec[255:240]}, {240'd0, fexp[255:240]});
        chk_out("timeout_off", 1'b0, 2'd0, 1'b0);

        // Owner presses again while in ON: the lamp turns off
        do_press(3'b001);
        ticks(48);
        S1 = 1'b1;
        tick();
        S1 = 1'b0;
        chk_out("off_latency", 1'b1, 2'd1, 1'b1);
        tick();
        chk_out("owner_off", 1'b0, 2'd0, 1'b0);

        // A non-owner press takes over and restarts the timer
        do_press(3'b001);
        ticks(98);
        S2 = 1'b1;
        tick();
        S2 = 1'b0;
        chk_out("takeover_mid", 1'b1, 2'd1, 1'b1);
        tick();
        chk_out("takeover", 1'b1, 2'd2, 1'b1);
        count_lit(lit);
        chk("takeover_lit", 256'(lit), 256'd256);

        // Simultaneous presses: S1 wins, and S2/S3 are dropped
        do_press(3'b111);
        chk_out("prio_s1", 1'b1, 2'd1, 1'b1);
        ticks(3);
        chk_out("prio_hold", 1'b1, 2'd1, 1'b1);
        do_press(3'b001);
        chk_out("prio_s1_off", 1'b0, 2'd0, 1'b0);

        // Owner press at cnt=10
        do_press(3'b001);
        ticks(244);  // cnt = 11
        chk_out("cnt11", warn_en ? 1'b0 : 1'b1, 2'd1, 1'b1);
        S1 = 1'b1;
        tick();      // cnt = 10, press pulse high
        S1 = 1'b0;
        tick();
        if (warn_en) begin
            chk_out("warn_rearm", 1'b1, 2'd1, 1'b1);
            count_lit(lit);
            chk("rearm_lit", 256'(lit), 256'd256);
        end else begin
            chk_out("nowarn_off", 1'b0, 2'd0, 1'b0);
        end

        // Reset mid-operation, with S1 held high across its release
        do_press(3'b001);
        ticks(127);  // cnt = 128
        #4 rst_n = 1'b0;
        S1 = 1'b1;
        #1 chk_out("async_rst", 1'b0, 2'd0, 1'b0);
        #5 rst_n = 1'b1;
        tick();
        chk_out("rel_edge1", 1'b0, 2'd0, 1'b0);
        tick();
        chk_out("rel_edge2_on", 1'b1, 2'd1, 1'b1);
        ticks(10);
        chk_out("held_one_press", 1'b1, 2'd1, 1'b1);
        S1 = 1'b0;
        ticks(3);
        chk_out("held_released", 1'b1, 2'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog: stops the run if the sequence above ever stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
